// File: rtl/ctrl_unit.sv
// ctrl_unit: fetch/decode/execute sequencer driving the 8-bit datapath controls.
// Define CTRL_CALL_EN to add CALL/RET with a one-deep return register.
module ctrl_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk_ctrl,
  input  logic       rst_ctrl,
  output logic [7:0] pc_ctrl,
  input  logic [7:0] instr_ctrl,
  output logic [1:0] muxsel_ctrl,
  output logic [7:0] imm_ctrl,
  output logic       accwr_ctrl,
  output logic [2:0] rfaddr_ctrl,
  output logic       rfwr_ctrl,
  output logic [2:0] alusel_ctrl,
  output logic [1:0] shiftsel_ctrl,
  output logic       outen_ctrl,
  input  logic       zero_ctrl,
  input  logic       positive_ctrl,
  output logic       halted_ctrl
);

  // state  | meaning
  // FETCH  | latch opcode byte into ir, pc+1
  // FETCH2 | latch operand byte into op2, pc+1
  // EXEC   | drive decoded controls for one cycle, resolve jumps
  // HALT   | controls idle, pc frozen until reset
  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_FETCH2 = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_STA  = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_ALU  = 4'h4;
  localparam logic [3:0] OP_IN   = 4'h5;
  localparam logic [3:0] OP_OUT  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_JPOS = 4'h9;
`ifdef CTRL_CALL_EN
  localparam logic [3:0] OP_CALL = 4'hA;
  localparam logic [3:0] OP_RET  = 4'hB;
`endif
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] op2_q, op2_d;
  logic       zflag_q, zflag_d;
  logic       pflag_q, pflag_d;
`ifdef CTRL_CALL_EN
  logic [7:0] ret_q, ret_d;
`endif

  logic [3:0] opc;
  logic       unused_ir3;

  assign opc        = ir_q[7:4];
  assign unused_ir3 = ir_q[3];

  function automatic logic is_two_byte(input logic [3:0] op);
    case (op)
      OP_LDI, OP_ALU, OP_JMP, OP_JZ, OP_JPOS: is_two_byte = 1'b1;
`ifdef CTRL_CALL_EN
      OP_CALL: is_two_byte = 1'b1;
`endif
      default: is_two_byte = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
    if (rst_ctrl) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = is_two_byte(instr_ctrl[7:4]) ? S_FETCH2 : S_EXEC;
      S_FETCH2: state_d = S_EXEC;
      S_EXEC:   state_d = (opc == OP_HALT) ? S_HALT : S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  always_comb begin
    muxsel_ctrl   = 2'b00;
    accwr_ctrl    = 1'b0;
    rfwr_ctrl     = 1'b0;
    alusel_ctrl   = 3'b000;
    shiftsel_ctrl = 2'b00;
    outen_ctrl    = 1'b0;
    if (state_q == S_EXEC) begin
      case (opc)
        OP_LDA: begin
          muxsel_ctrl = 2'b01;
          accwr_ctrl  = 1'b1;
        end
        OP_STA: rfwr_ctrl = 1'b1;
        OP_LDI: begin
          muxsel_ctrl = 2'b11;
          accwr_ctrl  = 1'b1;
        end
        OP_ALU: begin
          alusel_ctrl   = op2_q[4:2];
          shiftsel_ctrl = op2_q[1:0];
          accwr_ctrl    = 1'b1;
        end
        OP_IN: begin
          muxsel_ctrl = 2'b10;
          accwr_ctrl  = 1'b1;
        end
        OP_OUT:  outen_ctrl = 1'b1;
        default: ;
      endcase
    end
  end

  assign halted_ctrl = (state_q == S_HALT);
  assign pc_ctrl     = pc_q;
  assign imm_ctrl    = op2_q;
  assign rfaddr_ctrl = ir_q[2:0];

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    op2_d = op2_q;
`ifdef CTRL_CALL_EN
    ret_d = ret_q;
`endif
    case (state_q)
      S_FETCH: begin
        ir_d = instr_ctrl;
        pc_d = pc_q + 8'd1;
      end
      S_FETCH2: begin
        op2_d = instr_ctrl;
        pc_d  = pc_q + 8'd1;
      end
      S_EXEC: begin
        case (opc)
          OP_JMP:  pc_d = op2_q;
          OP_JZ:   if (zflag_q) pc_d = op2_q;
          OP_JPOS: if (pflag_q) pc_d = op2_q;
`ifdef CTRL_CALL_EN
          // pc already points past the operand byte, i.e. the return address
          OP_CALL: begin
            ret_d = pc_q;
            pc_d  = op2_q;
          end
          OP_RET:  pc_d = ret_q;
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Flags follow whatever value lands in the accumulator
  assign zflag_d = accwr_ctrl ? zero_ctrl     : zflag_q;
  assign pflag_d = accwr_ctrl ? positive_ctrl : pflag_q;

  always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
    if (rst_ctrl) begin
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      op2_q   <= 8'h00;
      zflag_q <= 1'b1;
      pflag_q <= 1'b1;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      op2_q   <= op2_d;
      zflag_q <= zflag_d;
      pflag_q <= pflag_d;
    end
  end

`ifdef CTRL_CALL_EN
  always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
    if (rst_ctrl) ret_q <= 8'h00;
    else          ret_q <= ret_d;
  end
`endif

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit with a behavioural program memory and accumulator model.
module tb_ctrl_unit;

  logic       clk_ctrl = 1'b0;
  logic       rst_ctrl = 1'b1;
  logic [7:0] pc, instr, imm;
  logic [1:0] muxsel, shiftsel;
  logic       accwr, rfwr, outen, halted;
  logic [2:0] rfaddr, alusel;
  logic       zero, positive;

  logic       rst_w = 1'b1;
  logic [7:0] pc_w, instr_w, imm_w;
  logic [1:0] muxsel_w, shiftsel_w;
  logic       accwr_w, rfwr_w, outen_w, halted_w;
  logic [2:0] rfaddr_w, alusel_w;
  logic       zero_w = 1'b0;
  logic       pos_w  = 1'b0;

  logic [7:0] mem   [256];
  logic [7:0] mem_w [256];
  logic [7:0] acc_m;
  logic [7:0] rf_m  [8];
  logic [7:0] in_v = 8'h00;
  logic [7:0] mux_v;
  logic [10:0] ctl_v;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk_ctrl = ~clk_ctrl;

  ctrl_unit u_dut (
    .clk_ctrl(clk_ctrl), .rst_ctrl(rst_ctrl), .pc_ctrl(pc), .instr_ctrl(instr),
    .muxsel_ctrl(muxsel), .imm_ctrl(imm), .accwr_ctrl(accwr), .rfaddr_ctrl(rfaddr),
    .rfwr_ctrl(rfwr), .alusel_ctrl(alusel), .shiftsel_ctrl(shiftsel),
    .outen_ctrl(outen), .zero_ctrl(zero), .positive_ctrl(positive),
    .halted_ctrl(halted)
  );

  ctrl_unit #(.RESET_PC(8'hFE)) u_wrap (
    .clk_ctrl(clk_ctrl), .rst_ctrl(rst_w), .pc_ctrl(pc_w), .instr_ctrl(instr_w),
    .muxsel_ctrl(muxsel_w), .imm_ctrl(imm_w), .accwr_ctrl(accwr_w), .rfaddr_ctrl(rfaddr_w),
    .rfwr_ctrl(rfwr_w), .alusel_ctrl(alusel_w), .shiftsel_ctrl(shiftsel_w),
    .outen_ctrl(outen_w), .zero_ctrl(zero_w), .positive_ctrl(pos_w),
    .halted_ctrl(halted_w)
  );

  assign instr   = mem[pc];
  assign instr_w = mem_w[pc_w];
  assign ctl_v   = {muxsel, accwr, rfwr, alusel, shiftsel, outen, halted};

  // Datapath stand-in; the ALU passes the accumulator through.
  always_comb begin
    case (muxsel)
      2'b00:   mux_v = acc_m;
      2'b01:   mux_v = rf_m[rfaddr];
      2'b10:   mux_v = in_v;
      default: mux_v = imm;
    endcase
  end

  // Outside accumulator writes the flag inputs are inverted so any stray capture shows up.
  assign zero     = accwr ? (mux_v == 8'h00) : (mux_v != 8'h00);
  assign positive = accwr ? ~mux_v[7] : mux_v[7];

  always @(posedge clk_ctrl or posedge rst_ctrl) begin
    if (rst_ctrl) acc_m <= 8'h00;
    else if (accwr) acc_m <= mux_v;
  end

  always @(posedge clk_ctrl) begin
    if (!rst_ctrl && rfwr) rf_m[rfaddr] <= acc_m;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_ctrl);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
  endtask

  // Leaves the bench sampling cycle 1 (first FETCH) after reset release.
  task automatic do_reset();
    rst_ctrl = 1'b1;
    tick();
    tick();
    rst_ctrl = 1'b0;
    #1;
  endtask

  logic [7:0] pcs [1:32];
  int n_acc, c_acc, n_rf, c_rf, n_out, c_out, bad_h;
  logic [1:0] mx_acc, sh_rec, mx_rec;
  logic [7:0] imm_acc;
  logic [2:0] ra_rf, al_rec, ra_rec;
  logic       aw_rec;
  logic [10:0] ctl_rec;
  logic [7:0] exp_seq [6];

  initial begin
    for (int i = 0; i < 256; i++) mem_w[i] = 8'hF0;
    clear_mem();

    // LDI 05; STA 3; OUT; HALT
    mem[8'h00] = 8'h30; mem[8'h01] = 8'h05; mem[8'h02] = 8'h23;
    mem[8'h03] = 8'h60; mem[8'h04] = 8'hF0;
    do_reset();
    chk("rst_pc", pc, 8'h00);
    chk("rst_ctl", ctl_v, 11'h000);
    chk("rst_imm", imm, 8'h00);
    n_acc = 0; n_rf = 0; n_out = 0; c_acc = 0; c_rf = 0; c_out = 0;
    for (int k = 1; k <= 9; k++) begin
      pcs[k] = pc;
      if (accwr) begin n_acc++; c_acc = k; mx_acc = muxsel; imm_acc = imm; end
      if (rfwr)  begin n_rf++;  c_rf = k;  ra_rf = rfaddr; end
      if (outen) begin n_out++; c_out = k; end
      tick();
    end
    chk("t1_acc_cnt", n_acc, 1);
    chk("t1_acc_cyc", c_acc, 3);
    chk("t1_acc_mux", mx_acc, 2'b11);
    chk("t1_acc_imm", imm_acc, 8'h05);
    chk("t1_rf_cnt", n_rf, 1);
    chk("t1_rf_cyc", c_rf, 5);
    chk("t1_rf_addr", ra_rf, 3'd3);
    chk("t1_out_cnt", n_out, 1);
    chk("t1_out_cyc", c_out, 7);
    chk("t1_pc_after", pcs[8], 8'h04);
    chk("t1_rf3", rf_m[3], 8'h05);

    // Now in HALT: pc frozen at 05
    chk("halt_flag", halted, 1'b1);
    chk("halt_pc", pc, 8'h05);
    bad_h = 0;
    for (int k = 0; k < 20; k++) begin
      if (!halted || pc != 8'h05 || ctl_v != 11'h001) bad_h++;
      tick();
    end
    chk("halt_hold", bad_h, 0);

    // LDI 4; STA 1; LDI 3; ALU 1 (op2=01); JZ 20; HALT
    clear_mem();
    mem[8'h00] = 8'h30; mem[8'h01] = 8'h04; mem[8'h02] = 8'h21;
    mem[8'h03] = 8'h30; mem[8'h04] = 8'h03; mem[8'h05] = 8'h41;
    mem[8'h06] = 8'h01; mem[8'h07] = 8'h80; mem[8'h08] = 8'h20;
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      pcs[k] = pc;
      if (k == 11) begin
        al_rec = alusel; sh_rec = shiftsel; mx_rec = muxsel; aw_rec = accwr; ra_rec = rfaddr;
      end
      tick();
    end
    chk("alu_alusel", al_rec, 3'b000);
    chk("alu_shift", sh_rec, 2'b01);
    chk("alu_mux", mx_rec, 2'b00);
    chk("alu_accwr", aw_rec, 1'b1);
    chk("alu_rfaddr", ra_rec, 3'd1);
    chk("alu_r1", rf_m[1], 8'h04);
    chk("alu_acc", acc_m, 8'h03);
    chk("alu_jz_fall", pcs[15], 8'h09);

    // LDI 0; STA 2; JZ 20 -> taken, STA must not disturb zflag
    clear_mem();
    mem[8'h00] = 8'h30; mem[8'h01] = 8'h00; mem[8'h02] = 8'h22;
    mem[8'h03] = 8'h80; mem[8'h04] = 8'h20;
    do_reset();
    for (int k = 1; k < 9; k++) tick();
    chk("jz_taken", pc, 8'h20);
    chk("jz_r2", rf_m[2], 8'h00);

    // LDI 80; JPOS 20 -> falls through to 04
    clear_mem();
    mem[8'h00] = 8'h30; mem[8'h01] = 8'h80; mem[8'h02] = 8'h90; mem[8'h03] = 8'h20;
    do_reset();
    for (int k = 1; k < 7; k++) tick();
    chk("jpos_fall", pc, 8'h04);

    // IN (7F); JPOS 30 -> taken
    clear_mem();
    in_v = 8'h7F;
    mem[8'h00] = 8'h50; mem[8'h01] = 8'h90; mem[8'h02] = 8'h30;
    do_reset();
    tick();
    chk("in_mux", muxsel, 2'b10);
    chk("in_accwr", accwr, 1'b1);
    for (int k = 2; k < 6; k++) tick();
    chk("jpos_taken", pc, 8'h30);
    chk("in_acc", acc_m, 8'h7F);

    // Reset lands during EXEC of STA 3: no write reaches R3
    clear_mem();
    mem[8'h00] = 8'h30; mem[8'h01] = 8'h66; mem[8'h02] = 8'h23;
    do_reset();
    for (int k = 1; k < 4; k++) tick();
    @(negedge clk_ctrl);
    chk("rst_sta_exec", rfwr, 1'b1);
    rst_ctrl = 1'b1;
    #1;
    chk("rst_mid_ctl", ctl_v, 11'h000);
    chk("rst_mid_pc", pc, 8'h00);
    tick();
    chk("rst_mid_r3", rf_m[3], 8'h05);
    rst_ctrl = 1'b0;

    // JMP 10; at 10: CALL 40 (or NOP); at 40: RET
    clear_mem();
    mem[8'h00] = 8'h70; mem[8'h01] = 8'h10;
    mem[8'h10] = 8'hA0; mem[8'h11] = 8'h40; mem[8'h12] = 8'hF0;
    mem[8'h40] = 8'hB0; mem[8'h41] = 8'hF0;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      pcs[k] = pc;
      if (k == 5) ctl_rec = ctl_v;
      tick();
    end
    chk("call_ctl_c5", ctl_rec, 11'h000);
`ifdef CTRL_CALL_EN
    exp_seq[0] = 8'h10; exp_seq[1] = 8'h11; exp_seq[2] = 8'h12;
    exp_seq[3] = 8'h40; exp_seq[4] = 8'h41; exp_seq[5] = 8'h12;
    for (int k = 0; k < 6; k++) chk($sformatf("call_pc%0d", k), pcs[k+4], exp_seq[k]);
`else
    exp_seq[0] = 8'h10; exp_seq[1] = 8'h11; exp_seq[2] = 8'h11;
    for (int k = 0; k < 3; k++) chk($sformatf("nocall_pc%0d", k), pcs[k+4], exp_seq[k]);
`endif

    // Wrap: JMP at FE/FF (operand at FF, pc rolls to 00); NOP at FF -> 00
    mem_w[8'hFE] = 8'h70; mem_w[8'hFF] = 8'hC0;
    mem_w[8'hC0] = 8'h70; mem_w[8'hC1] = 8'hFF;
    mem_w[8'h00] = 8'h70; mem_w[8'h01] = 8'hFF;
    rst_w = 1'b1;
    tick();
    rst_w = 1'b0;
    #1;
    exp_seq[0] = 8'hFE; exp_seq[1] = 8'hFF; exp_seq[2] = 8'h00;
    exp_seq[3] = 8'hC0; exp_seq[4] = 8'hC1; exp_seq[5] = 8'hC2;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("wrap_pc%0d", k), pc_w, exp_seq[k]);
      tick();
    end
    chk("wrap_fetch_ff", pc_w, 8'hFF);
    tick();
    chk("wrap_nop_ff", pc_w, 8'h00);
    tick();
    chk("wrap_next", pc_w, 8'h00);
    chk("wrap_halted", halted_w, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
